// File: rtl/fp_div_seq_ctrl_if.sv
// Handshake bundle for fp_div_seq_ctrl: operand request channel and result channel.
// FP_DIV_FLAGS_EN adds the 5-bit exception flags travelling with the result.
interface fp_div_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy, flags
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy, flags
  );
`else
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );
`endif
endinterface

// File: rtl/fp_div_seq_ctrl.sv
// Multicycle single-precision divider controller: screen specials, restoring divide, RNE round, hold result.
// Optional FP_DIV_FLAGS_EN adds {invalid, div_by_zero, overflow, underflow, inexact} alongside result.
module fp_div_seq_ctrl #(
  parameter int BPC = 1
) (
  input logic              clk,
  input logic              rst,
  fp_div_seq_ctrl_if.slave bus
);
  localparam int K  = 26 / BPC;
  localparam int CW = $clog2(K);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_reg;
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;
  logic signed [9:0] exp_reg;
  logic [23:0]       sb_reg;
  logic [24:0]       rem_reg;
  logic [25:0]       q_reg;
  logic [CW-1:0]     cnt_reg;
  logic              out_valid_reg;
  logic [31:0]       result_reg;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] fa;
  logic [22:0] fb;
  logic        sign;
  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;
  logic        nan_case;
  logic        special;
  logic [31:0] special_result;

  assign ea   = a_reg[30:23];
  assign eb   = b_reg[30:23];
  assign fa   = a_reg[22:0];
  assign fb   = b_reg[22:0];
  assign sign = a_reg[31] ^ b_reg[31];

  // Denormals are flushed: any zero exponent counts as zero regardless of fraction.
  assign a_zero = (ea == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_zero = (eb == 8'h00);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  assign nan_case = a_nan | b_nan | b_zero | (a_inf & b_inf);
  assign special  = nan_case | a_inf | a_zero | b_inf;

  always_comb begin
    special_result = 32'h0000_0000;
    if (nan_case) begin
      special_result = {sign, 8'hFF, 23'd1};
    end else if (a_inf) begin
      special_result = {sign, 8'hFF, 23'd0};
    end
  end

  logic [23:0]       sa0;
  logic [23:0]       sb0;
  logic signed [9:0] e0;
  logic signed [9:0] e_init;
  logic              pre_shift;
  logic [24:0]       rem_init;

  assign sa0       = {1'b1, fa};
  assign sb0       = {1'b1, fb};
  assign e0        = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
  assign pre_shift = (sa0 < sb0);
  // Doubling a small dividend keeps the quotient in [1,2), so q[25] is always the hidden bit.
  assign e_init    = pre_shift ? (e0 - 10'sd1) : e0;
  assign rem_init  = pre_shift ? {sa0, 1'b0} : {1'b0, sa0};

  logic [BPC-1:0] qbits;
  logic [24:0]    rem_next;
  logic [25:0]    q_next;

  genvar gi;
  generate
    for (gi = 0; gi < BPC; gi++) begin : g_step
      logic [24:0] rin;
      logic [24:0] rsub;
      logic [24:0] keep;
      logic [24:0] rout;
      logic        ge;
      if (gi == 0) begin : g_src
        assign rin = rem_reg;
      end else begin : g_src
        assign rin = g_step[gi-1].rout;
      end
      // Partial remainder stays below 2*sb, so 25 bits never overflow after the shift.
      assign ge   = (rin >= {1'b0, sb_reg});
      assign rsub = rin - {1'b0, sb_reg};
      assign keep = ge ? rsub : rin;
      assign rout = keep << 1;
      assign qbits[BPC-1-gi] = ge;
    end
  endgenerate

  assign rem_next = g_step[BPC-1].rout;
  assign q_next   = {q_reg[25-BPC:0], qbits};

  logic              guard_bit;
  logic              round_bit;
  logic              sticky;
  logic              lsb;
  logic              round_up;
  logic              carry;
  logic [22:0]       frac;
  logic signed [9:0] e_rnd;
  logic              ovf;
  logic              unf;
  logic [31:0]       round_result;

  assign guard_bit = q_reg[1];
  assign round_bit = q_reg[0];
  assign sticky    = |rem_reg;
  assign lsb       = q_reg[2];
  assign round_up  = guard_bit & (round_bit | sticky | lsb);
  // All-ones significand plus an increment wraps frac to zero and bumps the exponent.
  assign carry     = round_up & (&q_reg[25:2]);
  assign frac      = q_reg[24:2] + {22'd0, round_up};
  assign e_rnd     = exp_reg + $signed({9'd0, carry});
  assign ovf       = (e_rnd >= 10'sd255);
  assign unf       = (e_rnd <= 10'sd0);

  always_comb begin
    round_result = {sign, e_rnd[7:0], frac};
    if (ovf) begin
      round_result = {sign, 8'hFF, 23'd0};
    end else if (unf) begin
      round_result = 32'h0000_0000;
    end
  end

`ifdef FP_DIV_FLAGS_EN
  logic [4:0] flags_reg;
  logic       div_by_zero;

  assign div_by_zero = b_zero & ~a_inf & ~a_nan;
  assign bus.flags   = flags_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      a_reg         <= 32'h0;
      b_reg         <= 32'h0;
      exp_reg       <= 10'sd0;
      sb_reg        <= 24'h0;
      rem_reg       <= 25'h0;
      q_reg         <= 26'h0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= 32'h0;
`ifdef FP_DIV_FLAGS_EN
      flags_reg     <= 5'd0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            state_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (special) begin
            result_reg    <= special_result;
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
`ifdef FP_DIV_FLAGS_EN
            flags_reg     <= {nan_case, div_by_zero, 3'b000};
`endif
          end else begin
            exp_reg   <= e_init;
            rem_reg   <= rem_init;
            sb_reg    <= sb0;
            q_reg     <= 26'h0;
            cnt_reg   <= '0;
            state_reg <= S_DIV;
          end
        end
        S_DIV: begin
          rem_reg <= rem_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(K - 1)) begin
            state_reg <= S_ROUND;
          end
        end
        S_ROUND: begin
          result_reg    <= round_result;
          out_valid_reg <= 1'b1;
          state_reg     <= S_DONE;
`ifdef FP_DIV_FLAGS_EN
          flags_reg     <= {2'b00, ovf, unf, guard_bit | round_bit | sticky | ovf | unf};
`endif
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
endmodule

// File: tb/tb_fp_div_seq_ctrl.sv
// Self-checking bench for fp_div_seq_ctrl: directed vector table, stall/reset sequences, random ops vs integer model.
module tb_fp_div_seq_ctrl;
  localparam int BPC = 1;
  localparam int K   = 26 / BPC;
  localparam int NORM_LAT = K + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_div_seq_ctrl_if bus();

  fp_div_seq_ctrl #(.BPC(BPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: exact quotient from wide integer division, then textbook round-to-nearest-even.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
    logic             s;
    int               ea, eb, e, p, drop;
    longint unsigned  ma, mb, num, q, r, mant, rest, half;
    bit               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, up;
    logic [31:0]      res;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    special = 1'b1;
    if (a_nan || b_nan || b_zero || (a_inf && b_inf)) return {s, 8'hFF, 23'd1};
    if (a_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_inf) return 32'h0;
    special = 1'b0;
    ma  = 64'h80_0000 | longint'(a[22:0]);
    mb  = 64'h80_0000 | longint'(b[22:0]);
    num = ma << 40;
    q   = num / mb;
    r   = num % mb;
    e   = ea - eb + 127;
    p   = 40;
    if (q < (64'd1 << 40)) begin
      p = 39;
      e = e - 1;
    end
    drop = p - 23;
    mant = q >> drop;
    rest = q & ((64'd1 << drop) - 1);
    half = 64'd1 << (drop - 1);
    up   = (rest > half) || ((rest == half) && ((r != 0) || mant[0]));
    mant = mant + (up ? 64'd1 : 64'd0);
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return 32'h0;
    res = {s, 8'(e), mant[22:0]};
    return res;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
  endtask

  // Called right after the acceptance edge; counts edges until out_valid is seen.
  task automatic wait_result(output logic [31:0] res, output int lat);
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = bus.result;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready_after_done", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    issue(a, b);
    wait_result(res, lat);
    $display("%s: a=%h b=%h result=%h (exp %h) latency=%0d (exp %0d)",
             tag, a, b, res, exp_res, lat, exp_lat);
    chk({tag, "_result"}, res, exp_res);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    consume();
  endtask

  initial begin
    logic [31:0] res, ra, rb, er;
    int          lat;
    bit          sp;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, NORM_LAT};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, NORM_LAT};
    vecs[2]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, NORM_LAT};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800001, 1};
    vecs[4]  = '{32'h7F800000, 32'hFF800000, 32'hFF800001, 1};
    vecs[5]  = '{32'h00000000, 32'h7F800000, 32'h00000000, 1};
    vecs[6]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, NORM_LAT};
    vecs[7]  = '{32'h00800000, 32'h4B000000, 32'h00000000, NORM_LAT};
    vecs[8]  = '{32'h3F800000, 32'h00000001, 32'h7F800001, 1};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 32'h7F800001, 1};
    vecs[10] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1};
    vecs[11] = '{32'hBF800000, 32'h7F800000, 32'h00000000, 1};
    vecs[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, NORM_LAT};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_result", bus.result, 32'h0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Consumer stalls 5 cycles while a new request is already waiting.
    issue(32'h40C00000, 32'h40000000);
    wait_result(res, lat);
    chk("stall_first_result", res, 32'h40400000);
    bus.in_valid = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_result", bus.result, 32'h40400000);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stall_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("stall_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    wait_result(res, lat);
    $display("stall_followup: result=%h latency=%0d", res, lat);
    chk("stall_followup_result", res, 32'h3EAAAAAB);
    chk("stall_followup_latency", 32'(lat), 32'(NORM_LAT));
    consume();

    // Reset pulse in the middle of DIV drops the operation silently.
    issue(32'h3F800000, 32'h40400000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("mid_rst_no_output", {31'd0, bus.out_valid}, 32'd0);
    $display("reset_mid_div: discarded operation, idle again");
    run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, NORM_LAT);

    for (int i = 0; i < 80; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra[30:23] = 8'h00;
        1: ra[30:23] = 8'hFF;
        2: rb[30:23] = 8'hFF;
        3: rb[30:23] = 8'h00;
        4: ra[22:0] = rb[22:0];
        5, 6, 7: begin
          ra[30:23] = 8'(120 + $urandom_range(0, 15));
          rb[30:23] = 8'(120 + $urandom_range(0, 15));
        end
        default: ;
      endcase
      er = ref_div(ra, rb, sp);
      run_op($sformatf("rand%0d", i), ra, rb, er, sp ? 1 : NORM_LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
